uart_rx_rtl: RTL and testbench

Serial UART receiver for the 8N1-style link driven by the team's UART transmitter. It synchronises the asynchronous `i_rx` line, detects and validates the start bit, and samples each data bit at mid-bit using a baud-tick counter. It presents each received word with a one-cycle data-valid pulse. It sits at the pad side of any block consuming UART traffic and mirrors the transmitter's parameters, so both ends are configured identically.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_rtl.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_rtl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e : frame state encoding. Both ends of the link use it.
//   baud_ticks() : clock cycles per bit time, using integer division.
//   PARITY_MODE  : the parity bit makes the total number of ones even
//                  (1'b0 = even). Only used with UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA_BITS = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4
  } uart_state_e;

  localparam logic PARITY_MODE = 1'b0;

  // Clock cycles per bit. The caller must keep the result >= 4, so that
  // the half-bit point lies strictly inside a bit.
  function automatic int baud_ticks(input int clk_freq, input int br);
    return clk_freq / br;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1, the idle level of the line. This way the
// receiver does not see a false start edge while coming out of reset.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_async : line, asynchronous to i_clk
//   o_sync  : line after two flops, safe to use in i_clk logic
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the line. meta_r may go metastable; sync_r is the clean copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= i_async;
      sync_r <= meta_r;
    end
  end

  assign o_sync = sync_r;

endmodule

// File: rtl/uart_rx_rtl.sv
// uart_rx_rtl: UART receiver for start + B_PER_T data bits (LSB first)
// [+ even parity] + stop frames.
// Build option: define UART_RX_PARITY_EN to add the parity bit and the
// o_parity_err port.
//   i_clk        : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_rx         : serial line, idle high, asynchronous
//   o_data       : last good word. It is held until the next good frame.
//   o_dv         : one-cycle pulse when o_data has just been updated
//   o_frame_err  : one-cycle pulse when the stop bit was sampled low
//   o_busy       : high while a frame is in progress
//   o_parity_err : one-cycle pulse on a parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_rtl
  import uart_pkg::*;
#(
  parameter int B_PER_T  = 8,
  parameter int BR       = 9600,
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx,
  output logic [B_PER_T-1:0] o_data,
  output logic               o_dv,
  output logic               o_frame_err,
  output logic               o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic               o_parity_err
`endif
);

  localparam int BAUD_TICKS = baud_ticks(CLK_FREQ, BR);
  localparam int CNT_W      = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam int IDX_W      = (B_PER_T > 1) ? $clog2(B_PER_T) : 1;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA_BITS;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] ST_STOP   = STOP;

  // Even parity over the data word. XOR with PARITY_MODE gives the bit the
  // transmitter should have sent.
  function automatic logic calc_parity(input logic [B_PER_T-1:0] d);
    return (^d) ^ PARITY_MODE;
  endfunction

  logic               rx_s;
  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [B_PER_T-1:0] shift_r;
  logic               armed_r;
  logic               par_err_r;
  logic [B_PER_T-1:0] data_r;
  logic               dv_r;
  logic               frame_err_r;
  logic               busy_r;
`ifdef UART_RX_PARITY_EN
  logic               parity_err_r;
`endif

  logic half_done_s;
  logic bit_done_s;
  logic last_bit_s;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_rx),
    .o_sync  (rx_s)
  );

  assign half_done_s = (cnt_r == CNT_W'(BAUD_TICKS / 2 - 1));
  assign bit_done_s  = (cnt_r == CNT_W'(BAUD_TICKS - 1));
  assign last_bit_s  = (idx_r == IDX_W'(B_PER_T - 1));

  // Next-state decode for the frame FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // The arm requirement stops a held-low line (break) from restarting frames.
        if (armed_r && !rx_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (half_done_s) begin
          state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // The FSM leaves at mid stop bit, leaving half a bit of slack before the next start.
        if (bit_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, tick/bit counters, arm flag and data shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      // The tick counter restarts on every state entry and at every bit boundary.
      if ((state_nxt_s != state_r) || bit_done_s || (state_r == ST_IDLE)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (state_nxt_s != ST_DATA) begin
        idx_r <= '0;
      end else if (bit_done_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end

      // Line order is LSB first, so each new bit enters at the MSB end.
      if ((state_r == ST_DATA) && bit_done_s) begin
        shift_r <= {rx_s, shift_r[B_PER_T-1:1]};
      end else begin
        shift_r <= shift_r;
      end

      if ((state_r == ST_IDLE) && (state_nxt_s == ST_IDLE)) begin
        armed_r <= armed_r | rx_s;
      end else begin
        armed_r <= 1'b0;
      end
    end
  end

  // Parity mismatch flag. It is captured at mid parity bit and checked in STOP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_err_r <= 1'b0;
    end else begin
`ifdef UART_RX_PARITY_EN
      if ((state_r == ST_PARITY) && bit_done_s) begin
        par_err_r <= rx_s ^ calc_parity(shift_r);
      end else if (state_r == ST_IDLE) begin
        par_err_r <= 1'b0;
      end else begin
        par_err_r <= par_err_r;
      end
`else
      par_err_r <= 1'b0;
`endif
    end
  end

  // Registered outputs. The result pulses are mutually exclusive by construction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r       <= '0;
      dv_r         <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      dv_r         <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= (state_r != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if ((state_r == ST_STOP) && bit_done_s) begin
        if (!rx_s) begin
          frame_err_r <= 1'b1;
        end else if (par_err_r) begin
`ifdef UART_RX_PARITY_EN
          parity_err_r <= 1'b1;
`endif
        end else begin
          data_r <= shift_r;
          dv_r   <= 1'b1;
        end
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign o_data       = data_r;
  assign o_dv         = dv_r;
  assign o_frame_err  = frame_err_r;
  assign o_busy       = busy_r;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_rtl.sv
// tb_uart_rx_rtl: directed bench for uart_rx_rtl at 16 clocks per bit.
module tb_uart_rx_rtl;

  localparam int BT = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       dv;
  logic       ferr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ferr_cyc = 0;
  int dv_cyc_q[$];
  logic [7:0] dv_dat_q[$];
  int start_cyc;

  uart_rx_rtl #(
    .B_PER_T  (8),
    .BR       (100_000),
    .CLK_FREQ (1_600_000)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .o_data       (data),
    .o_dv         (dv),
    .o_frame_err  (ferr),
    .o_busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: the value N means that edge N has just occurred.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampling at the falling edge.
  always @(negedge clk) begin
    if (dv) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc_q.push_back(cyc);
      dv_dat_q.push_back(data);
    end
    if (ferr) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
`ifdef UART_RX_PARITY_EN
    if (perr) perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame, starting 1 ns after an edge. The edge before the start
  // bit becomes cycle 0 of the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic has_par, input logic par_b);
    start_cyc = cyc;
    rx = 1'b0;
    wait_cyc(BT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BT);
    end
    if (has_par) begin
      rx = par_b;
      wait_cyc(BT);
    end
    rx = stop_b;
    wait_cyc(BT);
  endtask

  initial begin
    int dv0;
    int fe0;
    int g0;
    rst_n = 1'b0;
    rx    = 1'b1;
    #23;
    check("reset_data", 32'(data), 32'h0);
    check("reset_dv",   32'(dv),   32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(3 * BT);

    // Single byte 0xA5
    dv0 = dv_cnt;
    fe0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("single_dv_count", 32'(dv_cnt - dv0), 32'd1);
    if (dv_cyc_q.size() >= dv0 + 1) begin
      check("single_data",    32'(dv_dat_q[dv0]), 32'hA5);
      check("single_latency", 32'(dv_cyc_q[dv0] - start_cyc), 32'd155);
    end
    check("single_ferr", 32'(ferr_cnt - fe0), 32'd0);
    check("hold_data", 32'(data), 32'hA5);

    // Three frames sent back to back
    dv0 = dv_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd3);
    if (dv_cyc_q.size() >= dv0 + 3) begin
      check("b2b_data0", 32'(dv_dat_q[dv0]),     32'h00);
      check("b2b_data1", 32'(dv_dat_q[dv0 + 1]), 32'hFF);
      check("b2b_data2", 32'(dv_dat_q[dv0 + 2]), 32'h3C);
      check("b2b_gap01", 32'(dv_cyc_q[dv0 + 1] - dv_cyc_q[dv0]),     32'd160);
      check("b2b_gap12", 32'(dv_cyc_q[dv0 + 2] - dv_cyc_q[dv0 + 1]), 32'd160);
    end

    // Start glitch: line low for only 3 cycles
    dv0 = dv_cnt;
    fe0 = ferr_cnt;
    g0  = cyc;
    rx  = 1'b0;
    wait_cyc(3);
    rx  = 1'b1;
    wait_cyc(2);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    wait_cyc(7);
    check("glitch_at_cyc12", 32'(cyc - g0), 32'd12);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    wait_cyc(2 * BT);
    check("glitch_no_dv",   32'(dv_cnt - dv0),   32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("glitch_next_dv", 32'(dv_cnt - dv0), 32'd1);
    check("glitch_next_data", 32'(data), 32'h5A);

    // Framing error, followed by a line held low for 40 bit times
    dv0 = dv_cnt;
    fe0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    wait_cyc(40 * BT);
    check("ferr_count", 32'(ferr_cnt - fe0), 32'd1);
    check("ferr_latency", 32'(ferr_cyc - start_cyc), 32'd155);
    check("ferr_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("ferr_data_kept", 32'(data), 32'h5A);
    check("ferr_no_retrigger", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("ferr_next_dv", 32'(dv_cnt - dv0), 32'd1);
    check("ferr_next_data", 32'(data), 32'h42);
    check("ferr_once", 32'(ferr_cnt - fe0), 32'd1);

    // Reset asserted at data bit 4 of 0xC3
    dv0 = dv_cnt;
    fe0 = ferr_cnt;
    rx = 1'b0;
    wait_cyc(BT);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      wait_cyc(BT);
    end
    rx = 1'b0;
    wait_cyc(BT / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_data", 32'(data), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_dv",   32'(dv),   32'h0);
    check("rst_async_ferr", 32'(ferr), 32'h0);
    wait_cyc(BT / 2);
    for (int i = 5; i < 8; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      wait_cyc(BT);
    end
    rx = 1'b1;
    wait_cyc(BT);
    rst_n = 1'b1;
    wait_cyc(12 * BT);
    check("rst_no_dv",   32'(dv_cnt - dv0),   32'd0);
    check("rst_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("rst_next_dv", 32'(dv_cnt - dv0), 32'd1);
    check("rst_next_data", 32'(data), 32'h11);

`ifdef UART_RX_PARITY_EN
    // Parity on: 0x07 has three ones, so the parity bit must be 1
    dv0 = dv_cnt;
    fe0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("par_good_dv", 32'(dv_cnt - dv0), 32'd1);
    check("par_good_data", 32'(data), 32'h07);
    check("par_good_perr", 32'(perr_cnt - fe0), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    wait_cyc(2 * BT);
    check("par_bad_perr", 32'(perr_cnt - fe0), 32'd1);
    check("par_bad_no_dv", 32'(dv_cnt - dv0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
